// File: rtl/aes_pkg.sv
// Shared AES decryption types and the inverse S-box table.
//   aes_block_t : 128-bit AES state, byte 0 at [127:120], byte 15 at [7:0]
//   aes_byte_t  : one state byte
//   INV_SBOX    : 256-entry inverse substitution table, indexed by the input byte
//   inv_sbox()  : table lookup helper
package aes_pkg;

  typedef logic [127:0] aes_block_t;
  typedef logic [7:0]   aes_byte_t;

  localparam aes_byte_t INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic aes_byte_t inv_sbox(input aes_byte_t b);
    return INV_SBOX[b];
  endfunction

endpackage

// File: rtl/inv_sbox_lut.sv
// Single combinational inverse S-box lookup lane.
//   byte_i : byte to substitute
//   byte_o : INV_SBOX[byte_i]
module inv_sbox_lut
  import aes_pkg::*;
(
  input  aes_byte_t byte_i,
  output aes_byte_t byte_o
);

  always_comb byte_o = inv_sbox(byte_i);

endmodule

// File: rtl/inv_sub_bytes_seq.sv
// Sequential AES InvSubBytes stage. A captured block is substituted in place,
// BYTES_PER_CYCLE bytes per clock, then offered downstream until accepted.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : input handshake, in_block = state from inv_shift_rows
//   out_valid/out_ready : output handshake, out_block = InvSubBytes(in_block)
//   busy                : high while substitution is in progress
// Byte 0 is [127:120], byte 15 is [7:0] on both in_block and out_block.
module inv_sub_bytes_seq
  import aes_pkg::*;
#(
  parameter int unsigned BYTES_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_block,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block,
  output logic         busy
);

  localparam int unsigned N  = 16 / BYTES_PER_CYCLE;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  // Packed as 16 bytes so state byte k sits at blk_q[15-k].
  logic [15:0][7:0] blk_q, blk_d;

  aes_byte_t lut_in  [BYTES_PER_CYCLE];
  aes_byte_t lut_out [BYTES_PER_CYCLE];

  // Lane j serves state byte cnt*BPC + j.
  always_comb begin
    for (int unsigned j = 0; j < BYTES_PER_CYCLE; j++) begin
      lut_in[j] = blk_q[4'(15 - (32'(cnt_q) * BYTES_PER_CYCLE + j))];
    end
  end

  for (genvar g = 0; g < int'(BYTES_PER_CYCLE); g++) begin : g_lane
    inv_sbox_lut u_lut (
      .byte_i (lut_in[g]),
      .byte_o (lut_out[g])
    );
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    blk_d     = blk_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          blk_d   = in_block;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        busy = 1'b1;
        for (int unsigned j = 0; j < BYTES_PER_CYCLE; j++) begin
          blk_d[4'(15 - (32'(cnt_q) * BYTES_PER_CYCLE + j))] = lut_out[j];
        end
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        // Accepting the result frees the register, so a new block may land on the same edge.
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            blk_d   = in_block;
            cnt_d   = '0;
            state_d = BUSY;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
    end
  end

  assign out_block = blk_q;

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Scoreboard bench for inv_sub_bytes_seq at BYTES_PER_CYCLE = 1, 4, 16.
module tb_inv_sub_bytes_seq;

  localparam int LAT [3] = '{16, 4, 1};

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] in_block;
  logic         out_ready;
  logic [2:0]   in_valid;
  logic [2:0]   in_ready, out_valid, busy;
  logic [127:0] out_block [3];

  always #5 clk = ~clk;

  inv_sub_bytes_seq #(.BYTES_PER_CYCLE(1)) u_bpc1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_block(in_block), .out_valid(out_valid[0]), .out_ready(out_ready),
    .out_block(out_block[0]), .busy(busy[0]));
  inv_sub_bytes_seq #(.BYTES_PER_CYCLE(4)) u_bpc4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_block(in_block), .out_valid(out_valid[1]), .out_ready(out_ready),
    .out_block(out_block[1]), .busy(busy[1]));
  inv_sub_bytes_seq #(.BYTES_PER_CYCLE(16)) u_bpc16 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_block(in_block), .out_valid(out_valid[2]), .out_ready(out_ready),
    .out_block(out_block[2]), .busy(busy[2]));

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int sel    = 0;
  int last_acc = 0;
  logic [127:0] sb_q [$];
  int lat_q [$];
  logic prev_ov = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s bpc_idx=%0d got=%h expected=%h", name, sel, act, exp);
    end
  endtask

  // Monitor: latency on every out_valid rise, data on every output handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid[sel] && !prev_ov) begin
        if (lat_q.size() == 0) check("latency_unexpected", 128'(cyc), 128'(-1));
        else check("latency", 128'(cyc), 128'(lat_q.pop_front()));
      end
      if (out_valid[sel] && out_ready) begin
        if (sb_q.size() == 0) check("unexpected_output", out_block[sel], 128'hx);
        else check("out_block", out_block[sel], sb_q.pop_front());
      end
    end
    prev_ov <= out_valid[sel];
  end

  // Called just after a posedge. Returns just after the accepting edge.
  task automatic send(input logic [127:0] blk, input logic [127:0] exp,
                      input bit track, input bit hold);
    int t = 0;
    in_block      = blk;
    in_valid[sel] = 1'b1;
    @(negedge clk);
    while (!in_ready[sel]) begin
      t++;
      if (t > 200) begin
        check("accept_timeout", 128'(t), 128'(0));
        in_valid[sel] = 1'b0;
        return;
      end
      @(negedge clk);
    end
    if (track) begin
      sb_q.push_back(exp);
      lat_q.push_back(cyc + 1 + LAT[sel]);
    end
    @(posedge clk);
    #1;
    last_acc = cyc;
    if (!hold) in_valid[sel] = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb_q.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("drain_pending", 128'(sb_q.size()), 128'(0));
    @(posedge clk);
    #1;
  endtask

  logic [127:0] b2b_in  [4];
  logic [127:0] b2b_exp [4];
  int acc [4];

  initial begin
    b2b_in[0]  = 128'h00112233445566778899aabbccddeeff;
    b2b_exp[0] = 128'h52e3946686edd30297f962fe27c9997d;
    b2b_in[1]  = 128'h0123456789abcdeffedcba9876543210;
    b2b_exp[1] = 128'h0932680af20e80610c93c0e20ffda17c;
    b2b_in[2]  = {16{8'hff}};
    b2b_exp[2] = {16{8'h7d}};
    b2b_in[3]  = {4{32'h637c0001}};
    b2b_exp[3] = {4{32'h00015209}};

    rst = 1'b1;
    in_valid = '0;
    in_block = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      sel = d;
      check("reset_out_valid", 128'(out_valid[d]), 128'(0));
      check("reset_busy", 128'(busy[d]), 128'(0));
      check("reset_in_ready", 128'(in_ready[d]), 128'(1));
      check("reset_out_block", out_block[d], 128'h0);
    end
    @(posedge clk);
    #1;

    for (int d = 0; d < 3; d++) begin
      sel = d;
      out_ready = 1'b1;

      // All-zero block, plus BUSY-state flags right after capture.
      send(128'h0, {16{8'h52}}, 1'b1, 1'b0);
      @(negedge clk);
      check("busy_after_accept", 128'(busy[sel]), 128'(1));
      check("in_ready_in_busy", 128'(in_ready[sel]), 128'(0));
      drain();

      // Byte ordering.
      send(128'h0001637CFF0000000000000000000000,
           128'h520900017D5252525252525252525252, 1'b1, 1'b0);
      drain();

      // Output stall: result and flags held while out_ready is low.
      out_ready = 1'b0;
      send({16{8'h63}}, 128'h0, 1'b1, 1'b0);
      begin
        int t = 0;
        while (!out_valid[sel] && t < 100) begin
          @(negedge clk);
          t++;
        end
      end
      check("stall_out_valid_rise", 128'(out_valid[sel]), 128'(1));
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        check("stall_out_valid", 128'(out_valid[sel]), 128'(1));
        check("stall_out_block", out_block[sel], 128'h0);
        check("stall_in_ready", 128'(in_ready[sel]), 128'(0));
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      drain();

      // Back-to-back blocks with in_valid and out_ready held high.
      for (int i = 0; i < 4; i++) begin
        send(b2b_in[i], b2b_exp[i], 1'b1, (i < 3));
        acc[i] = last_acc;
      end
      for (int i = 1; i < 4; i++)
        check("b2b_interval", 128'(acc[i] - acc[i-1]), 128'(LAT[sel] + 1));
      drain();

      // Reset while BUSY discards the block.
      send(b2b_in[0], 128'h0, 1'b0, 1'b0);
      repeat ((LAT[sel] > 7) ? 7 : (LAT[sel] - 1)) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("midreset_out_valid", 128'(out_valid[sel]), 128'(0));
      check("midreset_busy", 128'(busy[sel]), 128'(0));
      check("midreset_in_ready", 128'(in_ready[sel]), 128'(1));
      check("midreset_out_block", out_block[sel], 128'h0);
      @(posedge clk);
      #1;
      send(b2b_in[1], b2b_exp[1], 1'b1, 1'b0);
      drain();
      repeat (3) @(posedge clk);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
